// File: rtl/ranging_scheduler.sv
// ranging_scheduler: round-robin scheduler for ultrasonic range sensors.
// Fires one sensor trigger at a time, times the synchronized echo pulse in
// microseconds, publishes the result with a one-cycle strobe, and keeps a
// per-sensor crash flag (echo width at or below a threshold).
//
// Ports:
//   clk             system clock
//   rst_n           synchronous active-low reset
//   enable          ranging runs while high (checked between slots only)
//   echo            raw asynchronous echo lines, one per sensor
//   crash_thresh_us crash threshold on echo width, in us
//   trigger         one-hot (or zero) trigger outputs
//   dist_us         last echo width in us, 0xFFFF on timeout
//   dist_id         sensor index that dist_us belongs to
//   dist_valid      one-cycle strobe when dist_us/dist_id update
//   timeout         high together with dist_valid when the slot timed out
//   is_crash        per-sensor crash flags, held between updates
//   any_crash       registered OR of is_crash
module ranging_scheduler #(
  parameter int NUM_SENSORS = 3,
  parameter int TRIG_CYCLES = 1000,
  parameter int CLKS_PER_US = 100,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 60000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         echo,
  input  logic [15:0]                    crash_thresh_us,
  output logic [NUM_SENSORS-1:0]         trigger,
  output logic [15:0]                    dist_us,
  output logic [$clog2(NUM_SENSORS)-1:0] dist_id,
  output logic                           dist_valid,
  output logic                           timeout,
  output logic [NUM_SENSORS-1:0]         is_crash,
  output logic                           any_crash
);

  localparam int IW = $clog2(NUM_SENSORS);
  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLKS_PER_US - 1);
  localparam logic [TW-1:0] TRIG_MAX  = TW'(TRIG_CYCLES - 1);
  localparam logic [15:0]   TOUT_LAST = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]   HOLD_LAST = 16'(HOLDOFF_US - 1);
  localparam logic [IW-1:0] ID_MAX    = IW'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t                 state;
  logic [NUM_SENSORS-1:0] echo_m, echo_s;
  logic [IW-1:0]          cur_id, next_id;
  logic [TW-1:0]          tcnt;
  logic [PW-1:0]          pre, pre_nxt;
  logic [15:0]            us_cnt, us_nxt;
  logic                   armed, tick, echo_cur;

  always_comb begin
    tick     = (pre == PRE_MAX);
    echo_cur = echo_s[cur_id];
    next_id  = (cur_id == ID_MAX) ? '0 : cur_id + IW'(1);
    pre_nxt  = tick ? '0 : pre + PW'(1);
    us_nxt   = (tick && us_cnt != 16'hFFFE) ? us_cnt + 16'd1 : us_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_id     <= '0;
      tcnt       <= '0;
      pre        <= '0;
      us_cnt     <= '0;
      armed      <= 1'b0;
      trigger    <= '0;
      dist_us    <= '0;
      dist_id    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      is_crash   <= '0;
      any_crash  <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      any_crash  <= |is_crash;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= TRIG;
            trigger <= NUM_SENSORS'(1) << cur_id;
            tcnt    <= '0;
          end
        end
        TRIG: begin
          if (tcnt == TRIG_MAX) begin
            trigger <= '0;
            state   <= WAIT_RISE;
            pre     <= '0;
            us_cnt  <= '0;
            armed   <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_RISE: begin
          // A rise only counts after a low has been seen inside this state,
          // so an echo still high from before the trigger is ignored.
          armed <= ~echo_cur;
          if (armed && echo_cur) begin
            state <= MEASURE;
            // The cycle in which the rise is seen is already one high cycle.
            if (CLKS_PER_US == 1) begin
              pre    <= '0;
              us_cnt <= 16'd1;
            end else begin
              pre    <= PW'(1);
              us_cnt <= '0;
            end
          end else if (tick && us_cnt == TOUT_LAST) begin
            state         <= HOLDOFF;
            pre           <= '0;
            us_cnt        <= '0;
            dist_us       <= 16'hFFFF;
            dist_id       <= cur_id;
            dist_valid    <= 1'b1;
            timeout       <= 1'b1;
            is_crash[cur_id] <= 1'b0;
          end else begin
            pre    <= pre_nxt;
            us_cnt <= us_nxt;
          end
        end
        MEASURE: begin
          if (!echo_cur) begin
            state            <= HOLDOFF;
            pre              <= '0;
            us_cnt           <= '0;
            dist_us          <= us_cnt;
            dist_id          <= cur_id;
            dist_valid       <= 1'b1;
            is_crash[cur_id] <= (us_cnt <= crash_thresh_us);
          end else if (tick && us_cnt == TOUT_LAST) begin
            state            <= HOLDOFF;
            pre              <= '0;
            us_cnt           <= '0;
            dist_us          <= 16'hFFFF;
            dist_id          <= cur_id;
            dist_valid       <= 1'b1;
            timeout          <= 1'b1;
            is_crash[cur_id] <= 1'b0;
          end else begin
            pre    <= pre_nxt;
            us_cnt <= us_nxt;
          end
        end
        HOLDOFF: begin
          if (tick && us_cnt == HOLD_LAST) begin
            cur_id <= next_id;
            if (enable) begin
              state   <= TRIG;
              trigger <= NUM_SENSORS'(1) << next_id;
              tcnt    <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            pre    <= pre_nxt;
            us_cnt <= us_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ranging_scheduler.md
RANGING_SCHEDULER -- requirements
Module: ranging_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, default 3: number of ultrasonic sensors served round-robin.
REQ-002 Parameter TRIG_CYCLES, default 1000: trigger pulse width in clk cycles (10 us at 100 MHz).
REQ-003 Parameter CLKS_PER_US, default 100: clk cycles per microsecond of echo time.
REQ-004 Parameter TIMEOUT_US, default 38000: maximum wait for echo rise, and maximum echo-high time, in us.
REQ-005 Parameter HOLDOFF_US, default 60000: quiet time after each slot before the next trigger, in us.
REQ-006 clk  input  1  system clock, single clock domain.
REQ-007 rst_n  input  1  reset; synchronous and active-low.
REQ-008 enable  input  1  ranging runs while high.
REQ-009 echo  input  NUM_SENSORS  raw echo lines, asynchronous.
REQ-010 crash_thresh_us  input  16  crash threshold in us of echo width.
REQ-011 trigger  output  NUM_SENSORS  per-sensor trigger; at most one bit high at any time.
REQ-012 dist_us  output  16  last completed echo width in us; 0xFFFF on timeout.
REQ-013 dist_id  output  $clog2(NUM_SENSORS)  sensor index for dist_us.
REQ-014 dist_valid  output  1  one-cycle strobe when dist_us/dist_id update.
REQ-015 timeout  output  1  high with dist_valid when the slot timed out.
REQ-016 is_crash  output  NUM_SENSORS  per-sensor crash flag, held between updates.
REQ-017 any_crash  output  1  OR of is_crash, registered.

Function
REQ-018 Each echo bit SHALL pass a 2-flop synchronizer; all logic uses the synchronized value (echo_s) only.
REQ-019 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-020 IDLE: when enable=1, load cur_id into the slot and go to TRIG next cycle; else stay.
REQ-021 TRIG: trigger[cur_id]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE; echo ignored during TRIG.
REQ-022 WAIT_RISE: on echo_s[cur_id] 0->1 edge go to MEASURE; an echo already high on entry SHALL NOT count until it falls and rises again.
REQ-023 MEASURE: prescaler counts clk from 0 to CLKS_PER_US-1 and wraps; each wrap increments a 16-bit us counter, saturating at 0xFFFE.
REQ-024 On echo_s[cur_id] 1->0 edge: in the next cycle dist_us=us counter (floor of high cycles / CLKS_PER_US), dist_id=cur_id, dist_valid=1, timeout=0; go to HOLDOFF.
REQ-025 Timeout: if WAIT_RISE or MEASURE lasts TIMEOUT_US us, publish dist_us=0xFFFF, timeout=1, dist_valid=1; go to HOLDOFF.
REQ-026 Crash update on every dist_valid: is_crash[dist_id]=1 iff timeout=0 and dist_us <= crash_thresh_us; else 0; other bits unchanged.
REQ-027 any_crash SHALL update the cycle after is_crash changes.
REQ-028 HOLDOFF: wait HOLDOFF_US us, advance cur_id (NUM_SENSORS-1 wraps to 0), then TRIG if enable=1 else IDLE.
REQ-029 enable falling mid-slot SHALL NOT abort the slot; it takes effect only at HOLDOFF exit.
REQ-030 Echo on non-selected sensors SHALL be ignored entirely.
REQ-031 dist_valid and timeout SHALL be low in all cycles except the publish cycle.

Reset
REQ-032 When rst_n=0 at a clk edge: state=IDLE, cur_id=0, trigger=0, dist_us=0, dist_id=0, dist_valid=0, timeout=0, is_crash=0, any_crash=0, all counters and synchronizers cleared.
REQ-033 Reset asserted mid-slot SHALL drop trigger on that same edge and discard the in-progress measurement without a dist_valid.

Verification (NUM_SENSORS=3, TRIG_CYCLES=10, CLKS_PER_US=10, TIMEOUT_US=200, HOLDOFF_US=50)
REQ-034 enable=1, sensor 0 echo high 1234 cycles -> trigger[0] high 10 cycles; dist_valid once, dist_id=0, dist_us=123, timeout=0.
REQ-035 Sensor 1 never echoes -> after 200 us of WAIT_RISE: dist_us=0xFFFF, timeout=1, is_crash[1]=0; next trigger is trigger[2], then trigger[0].
REQ-036 crash_thresh_us=100, sensor 2 echo 1000 cycles -> dist_us=100, is_crash[2]=1, any_crash=1 one cycle later; next sensor-2 echo 1010 cycles -> is_crash[2]=0.
REQ-037 Sensor 0 echo held high through TRIG and into WAIT_RISE -> no measurement until a fresh rise; echo on sensor 1 during sensor 0 slot has no effect.
REQ-038 enable dropped during MEASURE -> slot completes with dist_valid, HOLDOFF runs, FSM returns to IDLE, no further trigger.
REQ-039 rst_n=0 during TRIG -> trigger=0 at that edge, no dist_valid, all outputs at reset values; restart begins at sensor 0.
